// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage: computes ADD/SUB/AND/OR/SLT on accept and
// queues results in a small in-order buffer with valid/ready handshakes.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [7:0]       illegal_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [4:0]       rd;
        logic             illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          new_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rdy_en;
    logic [7:0]      ill_cnt;
    logic [WIDTH-1:0] alu_res;
    logic            alu_ill;
    logic            push, pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (in_alu_ctrl)
            4'b0010: alu_res = in_a + in_b;
            4'b0110: alu_res = in_a - in_b;
            4'b0000: alu_res = in_a & in_b;
            4'b0001: alu_res = in_a | in_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        new_entry.result  = alu_res;
        new_entry.zero    = (alu_res == '0);
        new_entry.rd      = in_rd;
        new_entry.illegal = alu_ill;
    end

    // rdy_en holds in_ready low through reset and until the first edge after release
    assign in_ready  = rdy_en && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ill_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && alu_ill && (ill_cnt != 8'hFF)) ill_cnt <= ill_cnt + 1'b1;
        end
    end

    // Stale entries stay in storage after a pop, so outputs are masked when empty
    assign head          = mem[rd_ptr];
    assign out_result    = out_valid ? head.result  : '0;
    assign out_zero      = out_valid ? head.zero    : 1'b0;
    assign out_rd        = out_valid ? head.rd      : 5'd0;
    assign out_illegal   = out_valid ? head.illegal : 1'b0;
    assign illegal_count = ill_cnt;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage against a queue-based
// reference model of the result buffer.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_ctrl;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    alu_exec_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   m_rdy;
    int   m_ic;
    int   tests = 0;
    int   fails = 0;
    logic [38:0] dut_bus;
    assign dut_bus = {out_result, out_zero, out_rd, out_illegal};

    function automatic exp_t ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        exp_t e;
        e.ill = 1'b0;
        e.rd  = rd;
        case (c)
            4'd2:    e.res = a + b;
            4'd6:    e.res = a - b;
            4'd0:    e.res = a & b;
            4'd1:    e.res = a | b;
            4'd7:    e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [38:0] exp_bus();
        if (q.size() == 0) return '0;
        return {q[0].res, q[0].zero, q[0].rd, q[0].ill};
    endfunction

    function automatic logic [1:0] exp_hs();
        return {q.size() != 0, m_rdy && (q.size() < 2)};
    endfunction

    task automatic drive(input bit v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid = v; in_alu_ctrl = c; in_a = a; in_b = b; in_rd = rd;
    endtask

    // Advance one clock; model sees the pre-edge state, then outputs settle for #1
    task automatic tick();
        bit push, pop;
        exp_t e;
        @(posedge clk);
        if (rst_n) begin
            push = in_valid && m_rdy && (q.size() < 2);
            pop  = (q.size() != 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                e = ref_alu(in_alu_ctrl, in_a, in_b, in_rd);
                q.push_back(e);
                if (e.ill && m_ic < 255) m_ic++;
            end
            m_rdy = 1'b1;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy = 1'b0;
        m_ic  = 0;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({out_valid, in_ready, illegal_count} !== 10'd0 || dut_bus !== 39'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b icnt=%0d bus=%h, want all 0",
                     out_valid, in_ready, illegal_count, dut_bus);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready_pre_edge: in_ready=%b want 0", in_ready);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_post_edge: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd7);
        tick();
        tests++;
        if ({out_valid, out_result, out_zero, out_rd, out_illegal} !== {1'b1, 32'h8000_0000, 1'b0, 5'd7, 1'b0}) begin
            fails++;
            $display("FAIL add_overflow: v=%b res=%h z=%b rd=%0d ill=%b want 1 80000000 0 7 0",
                     out_valid, out_result, out_zero, out_rd, out_illegal);
        end
        drive(1'b1, 4'b0110, 32'd5, 32'd5, 5'd3);
        tick();
        tests++;
        if ({out_result, out_zero, out_rd} !== {32'd0, 1'b1, 5'd3}) begin
            fails++;
            $display("FAIL sub_zero: res=%h z=%b rd=%0d want 0 1 3", out_result, out_zero, out_rd);
        end
        drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd9);
        tick();
        tests++;
        if ({out_result, out_zero} !== {32'd1, 1'b0}) begin
            fails++; $display("FAIL slt_signed: res=%h z=%b want 1 0", out_result, out_zero);
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        tick();
        tests++;
        if (out_valid !== 1'b0 || dut_bus !== 39'd0) begin
            fails++; $display("FAIL drain_empty: valid=%b bus=%h want 0 0", out_valid, dut_bus);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd1);
        tick();
        drive(1'b1, 4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd2);
        tick();
        tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++; $display("FAIL bp_full: valid=%b ready=%b want 1 0", out_valid, in_ready);
        end
        drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd3);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        tests++;
        if ({out_result, out_rd} !== {32'h00F0_1200, 5'd1} || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: res=%h rd=%0d ready=%b want 00f01200 1 0", out_result, out_rd, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({out_valid, out_result, out_rd} !== {1'b1, 32'hF000_000F, 5'd2}) begin
            fails++;
            $display("FAIL bp_order: v=%b res=%h rd=%0d want 1 f000000f 2", out_valid, out_result, out_rd);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_no_third: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd100, 32'd0, 5'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'b0010, $urandom, $urandom, 5'(i + 1));
            tick();
            tests++;
            if ({out_valid, in_ready} !== 2'b11 || exp_hs() !== 2'b11 || dut_bus !== exp_bus()) begin
                fails++;
                $display("FAIL stream[%0d]: v/r=%b%b bus=%h want 11 bus=%h", i, out_valid, in_ready,
                         dut_bus, exp_bus());
            end
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, (i % 2) ? 4'b0011 : 4'b1111, $urandom, $urandom, 5'(i));
            tick();
            tests++;
            if ({out_valid, out_result, out_zero, out_illegal} !== {1'b1, 32'd0, 1'b1, 1'b1} ||
                out_rd !== 5'(i) || illegal_count !== 8'(m_ic)) begin
                fails++;
                $display("FAIL illegal[%0d]: v=%b res=%h z=%b ill=%b rd=%0d icnt=%0d want 1 0 1 1 %0d %0d",
                         i, out_valid, out_result, out_zero, out_illegal, out_rd, illegal_count,
                         5'(i), m_ic);
            end
        end
        tests++;
        if (illegal_count !== 8'd255) begin
            fails++; $display("FAIL illegal_sat: icnt=%0d want 255", illegal_count);
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    task automatic test_random();
        logic [3:0] codes [8] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd15, 4'd3, 4'd9};
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)],
                  ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, $urandom, 5'($urandom));
            if (in_alu_ctrl == 4'd6 && $urandom_range(0, 3) == 0) in_b = in_a;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
            tests++;
            if ({out_valid, in_ready} !== exp_hs() || dut_bus !== exp_bus() || illegal_count !== 8'(m_ic)) begin
                fails++;
                $display("FAIL random[%0d]: v/r=%b%b bus=%h icnt=%0d want %b bus=%h icnt=%0d", i,
                         out_valid, in_ready, dut_bus, illegal_count, exp_hs(), exp_bus(), m_ic);
            end
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 4'b1111, 32'd1, 32'd2, 5'd4);
        tick();
        drive(1'b1, 4'b0001, 32'd8, 32'd1, 5'd5);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++; $display("FAIL rmid_full: v/r=%b%b want 10", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({out_valid, in_ready, illegal_count} !== 10'd0 || dut_bus !== 39'd0) begin
            fails++;
            $display("FAIL rmid_async: v=%b r=%b icnt=%0d bus=%h want all 0", out_valid, in_ready,
                     illegal_count, dut_bus);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid, in_ready} !== 2'b01 || dut_bus !== 39'd0 || illegal_count !== 8'd0) begin
                fails++;
                $display("FAIL rmid_stale[%0d]: v/r=%b%b bus=%h icnt=%0d want 01 0 0", i, out_valid,
                         in_ready, dut_bus, illegal_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
